// File: rtl/pc_sequencer.sv
// Program counter sequencer: single-step advance, one-cycle RESOLVE for
// jumps/branches/calls/returns, and a circular return-address stack.
module pc_sequencer #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int                STEP      = 4,
  parameter int                RAS_DEPTH = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Step,
  input  logic              Stall,
  input  logic              Jump,
  input  logic              Branch,
  input  logic              BranchTaken,
  input  logic              Call,
  input  logic              Ret,
  input  logic [ADDR_W-1:0] Target,
  output logic [ADDR_W-1:0] q,
  output logic [ADDR_W-1:0] q_plus,
  output logic              Busy,
  output logic              RasOvf,
  output logic              RasUnf
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  typedef enum logic       {IDLE, RESOLVE}        state_t;
  typedef enum logic [1:0] {K_TGT, K_CALL, K_RET} kind_t;

  state_t                          state;
  kind_t                           kind;
  logic                            step_d;
  logic [RAS_DEPTH-1:0][ADDR_W-1:0] ras;
  logic [PTR_W-1:0]                ptr;     // next write slot; top is ptr-1
  logic [CNT_W-1:0]                count;

  logic             step_ev, redirect, ras_full, ras_empty;
  logic [PTR_W-1:0] ptr_inc, ptr_dec;
  logic [ADDR_W-1:0] ras_top;

  always_comb begin
    q_plus    = q + ADDR_W'(STEP);
    step_ev   = Step & ~step_d;
    redirect  = Ret | Call | Jump | (Branch & BranchTaken);
    ras_full  = (count == CNT_W'(RAS_DEPTH));
    ras_empty = (count == '0);
    ptr_inc   = (ptr == PTR_W'(RAS_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    ptr_dec   = (ptr == '0) ? PTR_W'(RAS_DEPTH - 1) : ptr - PTR_W'(1);
    ras_top   = ras[ptr_dec];
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      q      <= RESET_VEC;
      state  <= IDLE;
      kind   <= K_TGT;
      step_d <= 1'b1;  // Step held through reset must not look like an edge
      ras    <= '0;
      ptr    <= '0;
      count  <= '0;
      Busy   <= 1'b0;
      RasOvf <= 1'b0;
      RasUnf <= 1'b0;
    end else begin
      step_d <= Step;
      RasOvf <= 1'b0;
      RasUnf <= 1'b0;
      if (!Stall) begin
        case (state)
          IDLE: begin
            if (step_ev) begin
              if (redirect) begin
                kind  <= Ret ? K_RET : (Call ? K_CALL : K_TGT);
                state <= RESOLVE;
                Busy  <= 1'b1;
              end else begin
                q <= q_plus;
              end
            end
          end
          RESOLVE: begin
            state <= IDLE;
            Busy  <= 1'b0;
            case (kind)
              K_CALL: begin
                // When full the write slot holds the oldest entry, so it is overwritten
                ras[ptr] <= q_plus;
                ptr      <= ptr_inc;
                if (ras_full) RasOvf <= 1'b1;
                else          count  <= count + CNT_W'(1);
                q <= Target;
              end
              K_RET: begin
                if (!ras_empty) begin
                  q     <= ras_top;
                  ptr   <= ptr_dec;
                  count <= count - CNT_W'(1);
                end else begin
                  q      <= Target;
                  RasUnf <= 1'b1;
                end
              end
              default: q <= Target;
            endcase
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
